// File: rtl/load_unit_if.sv
// Load unit bus bundle: request/status, register-file read/write, data-memory read.
//   master : environment side (issues start/instruction, returns rf/mem data)
//   slave  : load unit side
interface load_unit_if #(
    parameter int unsigned N = 32
);
    logic         start;
    logic [N-1:0] instruction;
    logic         busy;
    logic         done;
    logic         error;
    logic [4:0]   rf_read_addr;
    logic [N-1:0] rf_read_data;
    logic [N-1:0] mem_addr;
    logic         mem_read;
    logic         mem_ready;
    logic [N-1:0] mem_rdata;
    logic         rf_write_en;
    logic [4:0]   rf_write_addr;
    logic [N-1:0] rf_write_data;

    modport master (
        output start, instruction, rf_read_data, mem_ready, mem_rdata,
        input  busy, done, error, rf_read_addr, mem_addr, mem_read,
               rf_write_en, rf_write_addr, rf_write_data
    );

    modport slave (
        input  start, instruction, rf_read_data, mem_ready, mem_rdata,
        output busy, done, error, rf_read_addr, mem_addr, mem_read,
               rf_write_en, rf_write_addr, rf_write_data
    );
endinterface

// File: rtl/load_unit.sv
// Load unit: executes one I-type load (lw/lb/lbu/lh/lhu) per start request.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - load_unit_if.slave: start/instruction in, busy/done/error out,
//          rf read (addr out, data in), memory read handshake, rf write-back.
// All outputs are registered. Flow: IDLE -> ADDR -> MEM -> WB -> IDLE,
// or IDLE -> ADDR -> IDLE with a done+error pulse on a fault.
module load_unit #(
    parameter int unsigned N = 32
) (
    input logic        clk,
    input logic        rst,
    load_unit_if.slave bus
);

    localparam int unsigned OP_W  = 6;
    localparam int unsigned IMM_W = 16;

    localparam logic [OP_W-1:0] OP_LW  = 6'b100011;
    localparam logic [OP_W-1:0] OP_LB  = 6'b100000;
    localparam logic [OP_W-1:0] OP_LBU = 6'b100100;
    localparam logic [OP_W-1:0] OP_LH  = 6'b100001;
    localparam logic [OP_W-1:0] OP_LHU = 6'b100101;

    typedef enum logic [1:0] {IDLE, ADDR, MEM, WB} state_t;

    state_t             state;
    logic [OP_W-1:0]    op_q;
    logic [4:0]         rt_q;
    logic [IMM_W-1:0]   imm_q;
    logic [1:0]         ea_lo_q;

    logic [N-1:0]       ea_c;
    logic               fault_c;
    logic [7:0]         byte_c;
    logic [15:0]        half_c;
    logic [N-1:0]       ext_c;

    // Effective address, alignment/opcode fault, and lane-extracted load value.
    always_comb begin
        ea_c    = bus.rf_read_data + {{(N-IMM_W){imm_q[IMM_W-1]}}, imm_q};
        fault_c = 1'b0;
        case (op_q)
            OP_LW:         fault_c = (ea_c[1:0] != 2'b00);
            OP_LH, OP_LHU: fault_c = ea_c[0];
            OP_LB, OP_LBU: fault_c = 1'b0;
            default:       fault_c = 1'b1;
        endcase

        // Big-endian lanes: offset 0 is the most significant byte.
        byte_c = bus.mem_rdata[7:0];
        case (ea_lo_q)
            2'd0:    byte_c = bus.mem_rdata[31:24];
            2'd1:    byte_c = bus.mem_rdata[23:16];
            2'd2:    byte_c = bus.mem_rdata[15:8];
            default: byte_c = bus.mem_rdata[7:0];
        endcase
        half_c = ea_lo_q[1] ? bus.mem_rdata[15:0] : bus.mem_rdata[31:16];

        ext_c = bus.mem_rdata;
        case (op_q)
            OP_LB:   ext_c = {{(N-8){byte_c[7]}}, byte_c};
            OP_LBU:  ext_c = {{(N-8){1'b0}}, byte_c};
            OP_LH:   ext_c = {{(N-16){half_c[15]}}, half_c};
            OP_LHU:  ext_c = {{(N-16){1'b0}}, half_c};
            default: ext_c = bus.mem_rdata;
        endcase
    end

    // Control FSM with registered outputs; done/error/rf_write_en are one-cycle pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            op_q              <= '0;
            rt_q              <= '0;
            imm_q             <= '0;
            ea_lo_q           <= '0;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
            bus.error         <= 1'b0;
            bus.rf_read_addr  <= '0;
            bus.mem_addr      <= '0;
            bus.mem_read      <= 1'b0;
            bus.rf_write_en   <= 1'b0;
            bus.rf_write_addr <= '0;
            bus.rf_write_data <= '0;
        end else begin
            bus.done        <= 1'b0;
            bus.error       <= 1'b0;
            bus.rf_write_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q             <= bus.instruction[31:26];
                        rt_q             <= bus.instruction[20:16];
                        imm_q            <= bus.instruction[15:0];
                        bus.rf_read_addr <= bus.instruction[25:21];
                        bus.busy         <= 1'b1;
                        state            <= ADDR;
                    end
                end
                ADDR: begin
                    ea_lo_q <= ea_c[1:0];
                    if (fault_c) begin
                        bus.done  <= 1'b1;
                        bus.error <= 1'b1;
                        bus.busy  <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        bus.mem_read <= 1'b1;
                        bus.mem_addr <= {ea_c[N-1:2], 2'b00};
                        state        <= MEM;
                    end
                end
                MEM: begin
                    // Request and address stay put until the memory accepts.
                    if (bus.mem_ready) begin
                        bus.mem_read      <= 1'b0;
                        bus.rf_write_data <= ext_c;
                        bus.rf_write_addr <= rt_q;
                        bus.rf_write_en   <= (rt_q != 5'd0);
                        bus.done          <= 1'b1;
                        state             <= WB;
                    end
                end
                WB: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_unit.sv
module tb_load_unit;

    localparam int unsigned N = 32;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] word;
        logic        exp_err;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [4:0]  exp_waddr;
        logic [31:0] exp_data;
    } vec_t;

    logic clk;
    logic rst;
    logic [31:0] regs [32];
    logic [31:0] cur_word;

    int checks;
    int errors;

    load_unit_if #(.N(N)) bus ();

    load_unit #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.rf_read_data = regs[bus.rf_read_addr];
    assign bus.mem_rdata    = cur_word;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Issue one load and observe it until done (plus the trailing WB cycle).
    // lat is reported as the edge at which done is first sampled high, edge 0 = start.
    task automatic run_load(input logic [31:0] instr, input int waits, input bit poke,
                            output int lat, output logic err, output logic we_any,
                            output logic [4:0] waddr, output logic [31:0] wdata,
                            output logic saw_rd, output logic [31:0] maddr,
                            output int unstable);
        int  m;
        bit  done_seen;
        m = 0; done_seen = 0; lat = -1; err = 1'b0; we_any = 1'b0;
        waddr = '0; wdata = '0; saw_rd = 1'b0; maddr = '0; unstable = 0;
        bus.start       = 1'b1;
        bus.instruction = instr;
        bus.mem_ready   = (waits == 0);
        for (int k = 0; k < 30 && !done_seen; k++) begin
            @(posedge clk); #1;
            bus.start = poke && bus.mem_read;
            if (poke) bus.instruction = 32'hFFFF_FFFF;
            if (bus.rf_write_en) we_any = 1'b1;
            if (bus.mem_read) begin
                if (!saw_rd) maddr = bus.mem_addr;
                else if (bus.mem_addr !== maddr) unstable++;
                saw_rd = 1'b1;
                m++;
                bus.mem_ready = (m > waits);
            end else if (saw_rd && !bus.done) begin
                unstable++;
            end
            if (bus.done) begin
                done_seen = 1;
                lat   = k + 1;
                err   = bus.error;
                waddr = bus.rf_write_addr;
                wdata = bus.rf_write_data;
            end
        end
        bus.start = 1'b0;
        @(posedge clk); #1;
        if (bus.rf_write_en) we_any = 1'b1;
    endtask

    vec_t vecs [16];

    initial begin
        int          lat;
        logic        err, we, rd;
        logic [4:0]  wa;
        logic [31:0] wd, ma;
        int          unst;
        int          bad;

        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) regs[i] = '0;
        regs[4] = 32'd2;
        regs[6] = 32'hFFFF_FFF8;
        cur_word        = '0;
        bus.start       = 1'b0;
        bus.instruction = '0;
        bus.mem_ready   = 1'b0;

        // instr, word, err, mem_addr, we, waddr, data
        vecs[0]  = '{mk(6'b100011, 5'd4, 5'd1,  16'd2),      32'h1234_5678, 1'b0, 32'd4,      1'b1, 5'd1,  32'h1234_5678};
        vecs[1]  = '{mk(6'b100000, 5'd0, 5'd3,  16'd5),      32'h80FF_7F01, 1'b0, 32'd4,      1'b1, 5'd3,  32'hFFFF_FFFF};
        vecs[2]  = '{mk(6'b100100, 5'd0, 5'd3,  16'd5),      32'h80FF_7F01, 1'b0, 32'd4,      1'b1, 5'd3,  32'h0000_00FF};
        vecs[3]  = '{mk(6'b100000, 5'd0, 5'd3,  16'd7),      32'h80FF_7F01, 1'b0, 32'd4,      1'b1, 5'd3,  32'h0000_0001};
        vecs[4]  = '{mk(6'b100000, 5'd0, 5'd3,  16'd4),      32'h80FF_7F01, 1'b0, 32'd4,      1'b1, 5'd3,  32'hFFFF_FF80};
        vecs[5]  = '{mk(6'b100100, 5'd0, 5'd3,  16'd6),      32'h80FF_7F01, 1'b0, 32'd4,      1'b1, 5'd3,  32'h0000_007F};
        vecs[6]  = '{mk(6'b100001, 5'd0, 5'd2,  16'd2),      32'hA5A5_8001, 1'b0, 32'd0,      1'b1, 5'd2,  32'hFFFF_8001};
        vecs[7]  = '{mk(6'b100101, 5'd0, 5'd2,  16'd2),      32'hA5A5_8001, 1'b0, 32'd0,      1'b1, 5'd2,  32'h0000_8001};
        vecs[8]  = '{mk(6'b100001, 5'd0, 5'd2,  16'd0),      32'hA5A5_8001, 1'b0, 32'd0,      1'b1, 5'd2,  32'hFFFF_A5A5};
        vecs[9]  = '{mk(6'b100001, 5'd0, 5'd2,  16'd1),      32'hA5A5_8001, 1'b1, 32'd0,      1'b0, 5'd0,  32'h0};
        vecs[10] = '{mk(6'b101011, 5'd0, 5'd1,  16'd0),      32'h1111_1111, 1'b1, 32'd0,      1'b0, 5'd0,  32'h0};
        vecs[11] = '{mk(6'b100011, 5'd0, 5'd0,  16'd4),      32'h1111_2222, 1'b0, 32'd4,      1'b0, 5'd0,  32'h1111_2222};
        vecs[12] = '{mk(6'b100011, 5'd4, 5'd5,  16'd1),      32'h1111_1111, 1'b1, 32'd0,      1'b0, 5'd0,  32'h0};
        vecs[13] = '{mk(6'b100011, 5'd4, 5'd7,  16'hFFFE),   32'hCAFE_BABE, 1'b0, 32'd0,      1'b1, 5'd7,  32'hCAFE_BABE};
        vecs[14] = '{mk(6'b100011, 5'd6, 5'd10, 16'h0010),   32'h0BAD_F00D, 1'b0, 32'd8,      1'b1, 5'd10, 32'h0BAD_F00D};
        vecs[15] = '{mk(6'b100101, 5'd0, 5'd9,  16'h7FFE),   32'h1234_BEEF, 1'b0, 32'h7FFC,   1'b1, 5'd9,  32'h0000_BEEF};

        // Reset state, observed while reset is held.
        rst = 1'b0;
        #12;
        check("rst_busy",    32'(bus.busy), 32'd0);
        check("rst_done",    32'(bus.done), 32'd0);
        check("rst_error",   32'(bus.error), 32'd0);
        check("rst_mem_read", 32'(bus.mem_read), 32'd0);
        check("rst_we",      32'(bus.rf_write_en), 32'd0);
        check("rst_addrs",   {bus.mem_addr[21:0], bus.rf_read_addr, bus.rf_write_addr}, 32'd0);
        check("rst_wdata",   bus.rf_write_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Directed table, zero memory wait.
        for (int i = 0; i < 16; i++) begin
            cur_word = vecs[i].word;
            run_load(vecs[i].instr, 0, 1'b0, lat, err, we, wa, wd, rd, ma, unst);
            check($sformatf("v%0d_latency", i), 32'(lat), vecs[i].exp_err ? 32'd2 : 32'd3);
            check($sformatf("v%0d_error", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_rf_write_en", i), 32'(we), 32'(vecs[i].exp_we));
            check($sformatf("v%0d_busy_after", i), 32'(bus.busy), 32'd0);
            if (vecs[i].exp_err) begin
                check($sformatf("v%0d_no_mem_read", i), 32'(rd), 32'd0);
            end else begin
                check($sformatf("v%0d_mem_addr", i), ma, vecs[i].exp_addr);
                check($sformatf("v%0d_waddr", i), 32'(wa), 32'(vecs[i].exp_waddr));
                check($sformatf("v%0d_wdata", i), wd, vecs[i].exp_data);
            end
        end

        // Memory wait of three cycles with start pokes while busy.
        cur_word = 32'h1234_5678;
        run_load(mk(6'b100011, 5'd4, 5'd1, 16'd2), 3, 1'b1, lat, err, we, wa, wd, rd, ma, unst);
        check("wait_latency", 32'(lat), 32'd6);
        check("wait_mem_addr", ma, 32'd4);
        check("wait_stable", 32'(unst), 32'd0);
        check("wait_wdata", wd, 32'h1234_5678);
        check("wait_error", 32'(err), 32'd0);
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (bus.busy || bus.done || bus.mem_read || bus.rf_write_en) bad++;
        end
        check("wait_pokes_ignored", 32'(bad), 32'd0);

        // Reset during a memory wait aborts the load.
        cur_word        = 32'hDEAD_BEEF;
        bus.mem_ready   = 1'b0;
        bus.start       = 1'b1;
        bus.instruction = mk(6'b100011, 5'd4, 5'd1, 16'd2);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("abort_in_mem", 32'(bus.mem_read), 32'd1);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_mem_read", 32'(bus.mem_read), 32'd0);
        check("abort_mem_addr", bus.mem_addr, 32'd0);
        check("abort_rf_read_addr", 32'(bus.rf_read_addr), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (bus.busy || bus.done || bus.error || bus.mem_read || bus.rf_write_en) bad++;
        end
        check("abort_quiet_after", 32'(bad), 32'd0);

        // Normal operation resumes after the abort.
        cur_word = 32'h80FF_7F01;
        run_load(mk(6'b100000, 5'd0, 5'd3, 16'd7), 0, 1'b0, lat, err, we, wa, wd, rd, ma, unst);
        check("resume_latency", 32'(lat), 32'd3);
        check("resume_wdata", wd, 32'h0000_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
